// File: rtl/accumulator_unit_pkg.sv
// Shared types for the accumulator stage: op codes, FSM encoding and the flag bundle.
package accumulator_unit_pkg;

    localparam int unsigned OP_W    = 2;
    localparam int unsigned STATE_W = 2;

    typedef enum logic [OP_W-1:0] {
        OP_LOAD = 2'b00,
        OP_ADD  = 2'b01,
        OP_SUB  = 2'b10,
        OP_ADC  = 2'b11
    } op_e;

    // 2'b11 is unused and recovers to ST_IDLE
    typedef enum logic [STATE_W-1:0] {
        ST_IDLE   = 2'b00,
        ST_EXEC   = 2'b01,
        ST_RESULT = 2'b10
    } state_e;

    typedef struct packed {
        logic carry;
        logic ovf;
        logic neg;
        logic zero;
        logic sticky;
    } flags_t;

    localparam flags_t FLAGS_RESET = '{carry: 1'b0, ovf: 1'b0, neg: 1'b0, zero: 1'b1, sticky: 1'b0};

endpackage

// File: rtl/accumulator_unit_if.sv
// Command and result handshake bundle; master is the command source/result consumer.
interface accumulator_unit_if
    import accumulator_unit_pkg::*;
#(
    parameter int unsigned n = 8
);
    logic         in_valid;
    logic         in_ready;
    op_e          op;
    logic [n-1:0] D;
    logic         out_valid;
    logic         out_ready;
    logic [n-1:0] A;
    logic         C;
    logic         V;
    logic         N;
    logic         Z;
    logic         VS;

    modport master (
        output in_valid, op, D, out_ready,
        input  in_ready, out_valid, A, C, V, N, Z, VS
    );

    modport slave (
        input  in_valid, op, D, out_ready,
        output in_ready, out_valid, A, C, V, N, Z, VS
    );
endinterface

// File: rtl/accumulator_unit_addsub.sv
// Combinational n-bit adder/subtractor with carry-out and signed overflow.
module adder_subtractor #(
    parameter int unsigned n = 8
) (
    input  logic [n-1:0] X,
    input  logic [n-1:0] Y,
    input  logic         carryin,
    input  logic         SUB,
    output logic [n-1:0] S,
    output logic         carryout,
    output logic         v
);
    logic [n-1:0] y_eff;
    logic         cin_eff;
    logic [n-1:0] low_sum;
    logic [n:0]   full_sum;

    // SUB inverts Y and forces the +1; overflow is carry-into-MSB xor carry-out
    always_comb begin
        y_eff    = Y ^ {n{SUB}};
        cin_eff  = carryin | SUB;
        low_sum  = {1'b0, X[n-2:0]} + {1'b0, y_eff[n-2:0]} + n'(cin_eff);
        full_sum = {1'b0, X} + {1'b0, y_eff} + (n+1)'(cin_eff);
        S        = full_sum[n-1:0];
        carryout = full_sum[n];
        v        = low_sum[n-1] ^ full_sum[n];
    end
endmodule

// File: rtl/accumulator_unit.sv
// Accumulator stage: accepts one command, runs it through the adder, holds the result until taken.
module accumulator_unit
    import accumulator_unit_pkg::*;
#(
    parameter int unsigned n = 8
) (
    input logic              Clock,
    input logic              Reset,
    accumulator_unit_if.slave bus
);
    state_e       state_q, state_d;
    logic [n-1:0] a_q, a_d;
    logic [n-1:0] d_r_q, d_r_d;
    op_e          op_r_q, op_r_d;
    flags_t       flags_q, flags_d;
    logic         in_ready_q, in_ready_d;
    logic         out_valid_q, out_valid_d;

    logic [n-1:0] add_y;
    logic         add_cin;
    logic [n-1:0] add_s;
    logic         add_cout;
    logic         add_v;

    // Operand conditioning: subtraction is X + ~Y + 1, ADC feeds back the carry flag
    always_comb begin
        add_y   = (op_r_q == OP_SUB) ? ~d_r_q : d_r_q;
        add_cin = 1'b0;
        case (op_r_q)
            OP_SUB:  add_cin = 1'b1;
            OP_ADC:  add_cin = flags_q.carry;
            default: add_cin = 1'b0;
        endcase
    end

    adder_subtractor #(.n(n)) u_addsub (
        .X        (a_q),
        .Y        (add_y),
        .carryin  (add_cin),
        .SUB      (1'b0),
        .S        (add_s),
        .carryout (add_cout),
        .v        (add_v)
    );

    // Next-state, register-bank update and handshake decode
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        d_r_d   = d_r_q;
        op_r_d  = op_r_q;
        flags_d = flags_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    op_r_d  = bus.op;
                    d_r_d   = bus.D;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (op_r_q == OP_LOAD) begin
                    a_d            = d_r_q;
                    flags_d.carry  = 1'b0;
                    flags_d.ovf    = 1'b0;
                    flags_d.sticky = 1'b0;
                end else begin
                    a_d            = add_s;
                    flags_d.carry  = add_cout;
                    flags_d.ovf    = add_v;
                    flags_d.sticky = flags_q.sticky | add_v;
                end
                flags_d.neg  = a_d[n-1];
                flags_d.zero = (a_d == '0);
                state_d      = ST_RESULT;
            end
            ST_RESULT: begin
                if (bus.out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        in_ready_d  = (state_d == ST_IDLE);
        out_valid_d = (state_d == ST_RESULT);
    end

    // State and register bank, synchronous reset
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q     <= ST_IDLE;
            a_q         <= '0;
            d_r_q       <= '0;
            op_r_q      <= OP_LOAD;
            flags_q     <= FLAGS_RESET;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            d_r_q       <= d_r_d;
            op_r_q      <= op_r_d;
            flags_q     <= flags_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.A         = a_q;
    assign bus.C         = flags_q.carry;
    assign bus.V         = flags_q.ovf;
    assign bus.N         = flags_q.neg;
    assign bus.Z         = flags_q.zero;
    assign bus.VS        = flags_q.sticky;
endmodule

// File: tb/tb_accumulator_unit.sv
// Scoreboard bench for accumulator_unit (n=8).
module tb_accumulator_unit;
    import accumulator_unit_pkg::*;

    localparam int unsigned W = 8;

    typedef struct packed {
        logic [W-1:0] a;
        logic         c;
        logic         v;
        logic         n;
        logic         z;
        logic         vs;
    } res_t;

    localparam res_t RES_RESET = '{a: 8'h00, c: 1'b0, v: 1'b0, n: 1'b0, z: 1'b1, vs: 1'b0};

    logic Clock = 1'b0;
    logic Reset;

    always #5 Clock = ~Clock;

    accumulator_unit_if #(.n(W)) bus ();

    accumulator_unit #(.n(W)) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus)
    );

    res_t         sb[$];
    int           tests_run    = 0;
    int           tests_failed = 0;
    logic [W-1:0] m_a;
    logic         m_c, m_v, m_vs;

    function automatic res_t observed();
        res_t r;
        r.a  = bus.A;
        r.c  = bus.C;
        r.v  = bus.V;
        r.n  = bus.N;
        r.z  = bus.Z;
        r.vs = bus.VS;
        return r;
    endfunction

    task automatic model_reset();
        m_a  = '0;
        m_c  = 1'b0;
        m_v  = 1'b0;
        m_vs = 1'b0;
    endtask

    // Reference behaviour built from integer arithmetic, pushed to the scoreboard
    task automatic model_step(input op_e op, input logic [W-1:0] d);
        int   sa, sd, sr, ur;
        res_t e;
        sa = $signed(m_a);
        sd = $signed(d);
        case (op)
            OP_LOAD: begin
                m_a = d; m_c = 1'b0; m_v = 1'b0; m_vs = 1'b0;
            end
            OP_SUB: begin
                m_c  = (m_a >= d);
                sr   = sa - sd;
                m_v  = (sr < -128) || (sr > 127);
                m_a  = m_a - d;
                m_vs = m_vs | m_v;
            end
            default: begin
                ur   = int'(m_a) + int'(d) + ((op == OP_ADC) ? int'(m_c) : 0);
                sr   = sa + sd + ((op == OP_ADC) ? int'(m_c) : 0);
                m_c  = (ur > 255);
                m_v  = (sr < -128) || (sr > 127);
                m_a  = W'(ur);
                m_vs = m_vs | m_v;
            end
        endcase
        e.a  = m_a;
        e.c  = m_c;
        e.v  = m_v;
        e.n  = m_a[W-1];
        e.z  = (m_a == '0);
        e.vs = m_vs;
        sb.push_back(e);
    endtask

    // Issue one command and wait (bounded) for its result; lat counts edges after acceptance
    task automatic run_cmd(input op_e op, input logic [W-1:0] d, output bit timed_out, output int lat);
        timed_out = 1'b0;
        lat       = 0;
        for (int i = 0; i < 20 && bus.in_ready !== 1'b1; i++) begin
            @(posedge Clock); #1;
        end
        if (bus.in_ready !== 1'b1) begin
            timed_out = 1'b1;
            model_step(op, d);
            return;
        end
        bus.in_valid = 1'b1;
        bus.op       = op;
        bus.D        = d;
        @(posedge Clock); #1;
        bus.in_valid = 1'b0;
        bus.op       = OP_ADC;
        bus.D        = ~d;
        model_step(op, d);
        while (bus.out_valid !== 1'b1 && lat < 20) begin
            @(posedge Clock); #1;
            lat++;
        end
        if (bus.out_valid !== 1'b1) timed_out = 1'b1;
    endtask

    task automatic release_out();
        bus.out_ready = 1'b1;
        @(posedge Clock); #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        Reset        = 1'b1;
        bus.in_valid = 1'b1;
        bus.op       = OP_LOAD;
        bus.D        = 8'h55;
        repeat (2) begin
            @(posedge Clock); #1;
        end
        Reset        = 1'b0;
        bus.in_valid = 1'b0;
        model_reset();
        tests_run++;
        if (observed() !== RES_RESET || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_values: got res=%h ov=%b ir=%b want res=%h ov=0 ir=1",
                     observed(), bus.out_valid, bus.in_ready, RES_RESET);
        end
        repeat (2) begin
            @(posedge Clock); #1;
        end
        tests_run++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.A !== 8'h00) begin
            tests_failed++;
            $display("FAIL reset_beats_valid: got ov=%b ir=%b A=%h want ov=0 ir=1 A=00",
                     bus.out_valid, bus.in_ready, bus.A);
        end
    endtask

    task automatic test_load_add();
        op_e          ops[2] = '{OP_LOAD, OP_ADD};
        logic [W-1:0] ds[2]  = '{8'h7F, 8'h01};
        bit           to;
        int           lat;
        res_t         e;
        for (int i = 0; i < 2; i++) begin
            run_cmd(ops[i], ds[i], to, lat);
            e = sb.pop_front();
            tests_run++;
            if (to || lat != 1 || observed() !== e) begin
                tests_failed++;
                $display("FAIL load_add[%0d]: timeout=%0b lat=%0d got %h want %h (lat 1)", i, to, lat, observed(), e);
            end
            release_out();
        end
    endtask

    task automatic test_sub_borrow();
        op_e          ops[2] = '{OP_LOAD, OP_SUB};
        logic [W-1:0] ds[2]  = '{8'h05, 8'h07};
        bit           to;
        int           lat;
        res_t         e;
        for (int i = 0; i < 2; i++) begin
            run_cmd(ops[i], ds[i], to, lat);
            e = sb.pop_front();
            tests_run++;
            if (to || observed() !== e) begin
                tests_failed++;
                $display("FAIL sub_borrow[%0d]: timeout=%0b got %h want %h", i, to, observed(), e);
            end
            release_out();
        end
    endtask

    task automatic test_adc_carry();
        op_e          ops[3] = '{OP_LOAD, OP_ADD, OP_ADC};
        logic [W-1:0] ds[3]  = '{8'hFF, 8'h01, 8'h00};
        bit           to;
        int           lat;
        res_t         e;
        for (int i = 0; i < 3; i++) begin
            run_cmd(ops[i], ds[i], to, lat);
            e = sb.pop_front();
            tests_run++;
            if (to || observed() !== e) begin
                tests_failed++;
                $display("FAIL adc_carry[%0d]: timeout=%0b got %h want %h", i, to, observed(), e);
            end
            release_out();
        end
    endtask

    task automatic test_backpressure();
        bit   to;
        int   lat;
        res_t e;
        run_cmd(OP_LOAD, 8'h3C, to, lat);
        e = sb.pop_front();
        for (int c = 0; c < 5; c++) begin
            tests_run++;
            if (to || observed() !== e || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin
                tests_failed++;
                $display("FAIL backpressure_hold[%0d]: got res=%h ir=%b ov=%b want res=%h ir=0 ov=1",
                         c, observed(), bus.in_ready, bus.out_valid, e);
            end
            bus.in_valid = (c == 2);
            bus.op       = OP_ADD;
            bus.D        = 8'h11;
            @(posedge Clock); #1;
            bus.in_valid = 1'b0;
        end
        bus.out_ready = 1'b1;
        @(posedge Clock); #1;
        bus.out_ready = 1'b0;
        tests_run++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL backpressure_release: got ir=%b ov=%b want ir=1 ov=0", bus.in_ready, bus.out_valid);
        end
        @(posedge Clock); #1;
        tests_run++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || observed() !== e) begin
            tests_failed++;
            $display("FAIL backpressure_ignored: got ov=%b ir=%b res=%h want ov=0 ir=1 res=%h",
                     bus.out_valid, bus.in_ready, observed(), e);
        end
    endtask

    task automatic test_reset_in_exec();
        bit   to;
        int   lat;
        res_t e;
        run_cmd(OP_LOAD, 8'h20, to, lat);
        e = sb.pop_front();
        tests_run++;
        if (to || observed() !== e) begin
            tests_failed++;
            $display("FAIL reset_exec_setup: timeout=%0b got %h want %h", to, observed(), e);
        end
        release_out();
        for (int i = 0; i < 20 && bus.in_ready !== 1'b1; i++) begin
            @(posedge Clock); #1;
        end
        bus.in_valid = 1'b1;
        bus.op       = OP_ADD;
        bus.D        = 8'h10;
        @(posedge Clock); #1;
        bus.in_valid = 1'b0;
        Reset        = 1'b1;
        @(posedge Clock); #1;
        Reset        = 1'b0;
        model_reset();
        tests_run++;
        if (observed() !== RES_RESET || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_in_exec: got res=%h ov=%b ir=%b want res=%h ov=0 ir=1",
                     observed(), bus.out_valid, bus.in_ready, RES_RESET);
        end
        @(posedge Clock); #1;
        tests_run++;
        if (bus.out_valid !== 1'b0 || bus.A !== 8'h00) begin
            tests_failed++;
            $display("FAIL reset_in_exec_discard: got ov=%b A=%h want ov=0 A=00", bus.out_valid, bus.A);
        end
    endtask

    task automatic test_sticky();
        op_e          ops[4] = '{OP_LOAD, OP_ADD, OP_ADD, OP_LOAD};
        logic [W-1:0] ds[4]  = '{8'h7F, 8'h01, 8'h00, 8'h00};
        bit           to;
        int           lat;
        res_t         e;
        for (int i = 0; i < 4; i++) begin
            run_cmd(ops[i], ds[i], to, lat);
            e = sb.pop_front();
            tests_run++;
            if (to || observed() !== e) begin
                tests_failed++;
                $display("FAIL sticky[%0d]: timeout=%0b got %h want %h", i, to, observed(), e);
            end
            release_out();
        end
    endtask

    task automatic test_back_to_back();
        bit   to;
        int   lat;
        res_t e;
        op_e  op;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            op = (i == 0) ? OP_LOAD : op_e'($urandom_range(0, 3));
            run_cmd(op, W'($urandom), to, lat);
            e = sb.pop_front();
            tests_run++;
            if (to || lat != 1 || observed() !== e) begin
                tests_failed++;
                $display("FAIL back_to_back[%0d]: op=%0d timeout=%0b lat=%0d got %h want %h (lat 1)",
                         i, op, to, lat, observed(), e);
            end
            @(posedge Clock); #1;
            tests_run++;
            if (bus.in_ready !== 1'b1) begin
                tests_failed++;
                $display("FAIL back_to_back_ready[%0d]: got ir=%b want 1", i, bus.in_ready);
            end
        end
        bus.out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.op        = OP_LOAD;
        bus.D         = '0;
        bus.out_ready = 1'b0;
        model_reset();
        @(posedge Clock); #1;
        test_reset();
        test_load_add();
        test_sub_borrow();
        test_adc_carry();
        test_backpressure();
        test_reset_in_exec();
        test_sticky();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
